// File: rtl/stepper_phase_decoder.sv
// Decodes a monitored full-step bipolar coil pattern into step pulses, direction,
// absolute position and sticky error status for closed-loop position readback.
module stepper_phase_decoder #(
  parameter int p_count_limit = 200,
  parameter int p_stable      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_phase,
  input  logic       i_clr_err,
  output logic       o_step,
  output logic       o_dir,
  output logic [7:0] o_count,
  output logic [1:0] o_pos,
  output logic       o_locked,
  output logic       o_err,
  output logic [1:0] o_err_code
);

  localparam logic [7:0] c_limit  = 8'(p_count_limit);
  localparam logic [3:0] c_stable = 4'(p_stable);

  typedef enum logic {st_unlocked, st_locked} lock_state_e;

  lock_state_e state_q, state_d;
  logic [3:0] s1, s2, last;
  logic [3:0] cnt, run;
  logic       same, accept;
  logic       legal;
  logic [1:0] idx, delta;
  logic [1:0] ref_q, ref_d;
  logic [7:0] count_d;
  logic       dir_d, step_d;
  logic       err_ev;
  logic [1:0] err_code_ev;

  // cnt saturates at c_stable so a held value is accepted exactly once.
  always_comb begin
    same = (s2 == last);
    if (same) run = (cnt == c_stable) ? c_stable : cnt + 4'd1;
    else      run = 4'd1;
    accept = (run == c_stable) && !(same && (cnt == c_stable));
  end

  always_comb begin
    legal = 1'b1;
    idx   = 2'd0;
    case (s2)
      4'b1100: idx = 2'd0;
      4'b0110: idx = 2'd1;
      4'b0011: idx = 2'd2;
      4'b1001: idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    count_d     = o_count;
    dir_d       = o_dir;
    step_d      = 1'b0;
    err_ev      = 1'b0;
    err_code_ev = 2'b00;
    delta       = 2'(idx - ref_q);
    if (accept && (s2 != 4'b0000)) begin
      if (!legal) begin
        err_ev      = 1'b1;
        err_code_ev = 2'b01;
      end else if (state_q == st_unlocked) begin
        state_d = st_locked;
        ref_d   = idx;
      end else begin
        ref_d = idx;
        case (delta)
          2'd1: begin
            if (o_count < c_limit) begin
              count_d = o_count + 8'd1;
              dir_d   = 1'b1;
              step_d  = 1'b1;
            end else begin
              err_ev      = 1'b1;
              err_code_ev = 2'b11;
            end
          end
          2'd3: begin
            if (o_count > 8'd0) begin
              count_d = o_count - 8'd1;
              dir_d   = 1'b0;
              step_d  = 1'b1;
            end else begin
              err_ev      = 1'b1;
              err_code_ev = 2'b11;
            end
          end
          2'd2: begin
            err_ev      = 1'b1;
            err_code_ev = 2'b10;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1      <= '0;
      s2      <= '0;
      last    <= '0;
      cnt     <= '0;
      state_q <= st_unlocked;
      ref_q   <= '0;
      o_count <= '0;
      o_dir   <= 1'b0;
      o_step  <= 1'b0;
    end else begin
      s1      <= i_phase;
      s2      <= s1;
      last    <= s2;
      cnt     <= run;
      state_q <= state_d;
      ref_q   <= ref_d;
      o_count <= count_d;
      o_dir   <= dir_d;
      o_step  <= step_d;
    end
  end

  // A new error in the clearing cycle takes priority over the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err      <= 1'b0;
      o_err_code <= '0;
    end else if (err_ev && (!o_err || i_clr_err)) begin
      o_err      <= 1'b1;
      o_err_code <= err_code_ev;
    end else if (i_clr_err) begin
      o_err      <= 1'b0;
      o_err_code <= '0;
    end
  end

  assign o_locked = (state_q == st_locked);

  always_comb begin
    if (o_count == 8'd0)         o_pos = 2'b00;
    else if (o_count == c_limit) o_pos = 2'b01;
    else                         o_pos = 2'b10;
  end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Scoreboard bench: stimulus queues expected step/error events, a monitor pops
// them as the selected decoder emits o_step pulses or raises o_err.
module tb_stepper_phase_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] a_phase = 4'b0000;
  logic [3:0] b_phase = 4'b0000;

  logic       a_step, a_dir, a_locked, a_err;
  logic [7:0] a_count;
  logic [1:0] a_pos, a_code;
  logic       b_step, b_dir, b_locked, b_err;
  logic [7:0] b_count;
  logic [1:0] b_pos, b_code;

  logic       m_step, m_dir, m_locked, m_err;
  logic [7:0] m_count;
  logic [1:0] m_pos, m_code;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       is_err;
    logic       dir;
    logic [7:0] count;
    logic [1:0] code;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  stepper_phase_decoder #(.p_count_limit(200), .p_stable(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_phase(a_phase), .i_clr_err(clr & ~sel),
    .o_step(a_step), .o_dir(a_dir), .o_count(a_count), .o_pos(a_pos),
    .o_locked(a_locked), .o_err(a_err), .o_err_code(a_code)
  );

  stepper_phase_decoder #(.p_count_limit(4), .p_stable(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_phase(b_phase), .i_clr_err(clr & sel),
    .o_step(b_step), .o_dir(b_dir), .o_count(b_count), .o_pos(b_pos),
    .o_locked(b_locked), .o_err(b_err), .o_err_code(b_code)
  );

  assign m_step   = sel ? b_step   : a_step;
  assign m_dir    = sel ? b_dir    : a_dir;
  assign m_count  = sel ? b_count  : a_count;
  assign m_pos    = sel ? b_pos    : a_pos;
  assign m_locked = sel ? b_locked : a_locked;
  assign m_err    = sel ? b_err    : a_err;
  assign m_code   = sel ? b_code   : a_code;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic status(input string tag, input logic [7:0] cnt, input logic [1:0] pos,
                        input logic lck, input logic err, input logic [1:0] code,
                        input logic dir);
    chk({tag, ".count"},  m_count, cnt);
    chk({tag, ".pos"},    {6'd0, m_pos}, {6'd0, pos});
    chk({tag, ".locked"}, {7'd0, m_locked}, {7'd0, lck});
    chk({tag, ".err"},    {7'd0, m_err}, {7'd0, err});
    chk({tag, ".code"},   {6'd0, m_code}, {6'd0, code});
    chk({tag, ".dir"},    {7'd0, m_dir}, {7'd0, dir});
  endtask

  function automatic void push_step(input logic dir, input logic [7:0] count);
    ev_t e;
    e = '{is_err: 1'b0, dir: dir, count: count, code: 2'b00};
    exp_q.push_back(e);
  endfunction

  function automatic void push_err(input logic [1:0] code);
    ev_t e;
    e = '{is_err: 1'b1, dir: 1'b0, count: 8'd0, code: code};
    exp_q.push_back(e);
  endfunction

  task automatic hold(input logic [3:0] ph, input int n);
    if (sel) b_phase = ph;
    else     a_phase = ph;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_err();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
  endtask

  // Monitor: pops one expected event per o_step pulse or o_err rising edge.
  initial begin : monitor
    logic prev_err;
    ev_t  e;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_err = 1'b0;
      end else begin
        if (m_step) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_step", 8'd1, 8'd0);
          end else begin
            e = exp_q.pop_front();
            chk("step_kind", {7'd0, e.is_err}, 8'd0);
            chk("step_dir", {7'd0, m_dir}, {7'd0, e.dir});
            chk("step_count", m_count, e.count);
          end
        end
        if (m_err && !prev_err) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_err", {6'd0, m_code}, 8'd0);
          end else begin
            e = exp_q.pop_front();
            chk("err_kind", {7'd0, e.is_err}, 8'd1);
            chk("err_code", {6'd0, m_code}, {6'd0, e.code});
          end
        end
        prev_err = m_err;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    #1;
    status("reset_a", 8'd0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("reset_a.step", {7'd0, m_step}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Forward sweep on the 200-step decoder.
    hold(4'b1100, 5);
    #1; chk("lock_a", {7'd0, m_locked}, 8'd1);
    chk("lock_a.count", m_count, 8'd0);
    push_step(1'b1, 8'd1); hold(4'b0110, 5);
    push_step(1'b1, 8'd2); hold(4'b0011, 5);
    push_step(1'b1, 8'd3); hold(4'b1001, 5);
    push_step(1'b1, 8'd4); hold(4'b1100, 5);
    #1; status("fwd4", 8'd4, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1);

    push_step(1'b0, 8'd3); hold(4'b1001, 5);
    push_step(1'b0, 8'd2); hold(4'b0011, 5);
    #1; status("bwd2", 8'd2, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0);
    push_step(1'b0, 8'd1); hold(4'b0110, 5);
    push_step(1'b0, 8'd0); hold(4'b1100, 5);
    #1; status("bwd0", 8'd0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);

    // Backward at zero -> travel limit.
    push_err(2'b11); hold(4'b1001, 5);
    #1; status("limit0", 8'd0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0);
    clear_err();
    status("clr1", 8'd0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);

    // Reference is 1001, so 1100 is a forward step; then a skip.
    push_step(1'b1, 8'd1); hold(4'b1100, 5);
    push_err(2'b10); hold(4'b0011, 5);
    #1; status("skip", 8'd1, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1);
    push_step(1'b1, 8'd2); hold(4'b1001, 5);
    #1; chk("skip_sticky_code", {6'd0, m_code}, 8'd2);
    clear_err();

    // One-cycle illegal glitch between legal phases is invisible.
    hold(4'b1111, 1);
    push_step(1'b1, 8'd3); hold(4'b1100, 5);
    #1; status("glitch", 8'd3, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1);
    push_err(2'b01); hold(4'b1111, 3);
    hold(4'b1100, 5);
    #1; status("illegal", 8'd3, 2'b10, 1'b1, 1'b1, 2'b01, 1'b1);
    clear_err();

    // Idle pattern then the same phase again: no action.
    hold(4'b0000, 5);
    hold(4'b1100, 5);
    #1; status("idle_same", 8'd3, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1);

    // Latency: new value first sampled at E0, o_step high after E0+3.
    push_step(1'b1, 8'd4);
    a_phase = 4'b0110;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1; chk("lat_e2_step", {7'd0, m_step}, 8'd0);
    @(posedge clk);
    #1; chk("lat_e3_step", {7'd0, m_step}, 8'd1);
    chk("lat_e3_count", m_count, 8'd4);
    repeat (4) @(negedge clk);
    chk("queue_a_empty", 8'(exp_q.size()), 8'd0);

    // Switch to the 4-step decoder.
    sel = 1'b1;
    @(negedge clk);
    hold(4'b1100, 5);
    push_step(1'b1, 8'd1); hold(4'b0110, 5);
    push_step(1'b1, 8'd2); hold(4'b0011, 5);
    push_step(1'b1, 8'd3); hold(4'b1001, 5);
    push_step(1'b1, 8'd4); hold(4'b1100, 5);
    #1; status("top", 8'd4, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1);
    push_err(2'b11); hold(4'b0110, 5);
    #1; status("top_limit", 8'd4, 2'b01, 1'b1, 1'b1, 2'b11, 1'b1);

    // Mid-sequence asynchronous reset.
    b_phase = 4'b0011;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1; status("midrst", 8'd0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
    chk("midrst.step", {7'd0, m_step}, 8'd0);
    chk("midrst_queue", 8'(exp_q.size()), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1; status("relock", 8'd0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    push_step(1'b1, 8'd1); hold(4'b1001, 5);
    #1; status("after_relock", 8'd1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1);

    repeat (4) @(negedge clk);
    chk("queue_b_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stepper_phase_decoder.md
# stepper_phase_decoder

Decodes the full-step bipolar coil pattern (A,B,C,D) driven onto a stepper motor back into step events, direction, absolute step count and end-position status. It sits on the monitored coil lines beside the full-step driver and gives closed-loop position readback. It also flags illegal patterns, skipped steps and travel-limit violations.

## Interface

- p_count_limit, 200, upper travel limit in steps; count range 0..p_count_limit; must fit 8 bits.
- p_stable, 2, consecutive synchronized cycles a pattern must hold before acceptance; range 1..15.
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_phase  in  4  coil pattern, bit3=A, bit2=B, bit1=C, bit0=D; asynchronous to i_clk.
- i_clr_err  in  1  synchronous clear of the sticky error.
- o_step  out  1  one-cycle pulse per accepted legal step.
- o_dir  out  1  direction of the last accepted step: 1 forward, 0 backward.
- o_count  out  8  absolute step count.
- o_pos  out  2  position status: 00 at 0, 01 at p_count_limit, 10 in between.
- o_locked  out  1  a legal phase has been accepted since reset.
- o_err  out  1  sticky error flag.
- o_err_code  out  2  first error since clear: 00 none, 01 illegal pattern, 10 skipped step, 11 travel limit.

## Operation

- i_phase passes through a 2-flop synchronizer (reset 0000). Its output is s2.
- Phase map: 1100→0, 0110→1, 0011→2, 1001→3. 0000 means idle. Every other value is illegal.
- Stability filter: a s2 value is accepted once it has been unchanged for p_stable consecutive cycles. Each distinct held value is accepted once only. A value held fewer than p_stable cycles is discarded silently, with no error.
- Accepted 0000: no action.
- Accepted illegal pattern: error 01. Count, phase reference and lock are unchanged.
- First accepted legal phase after reset:
  - o_locked←1.
  - Phase reference←phase.
  - No o_step pulse; o_count unchanged.
- Later accepted legal phase, delta = (new − reference) mod 4:
  - 1: forward. If o_count < p_count_limit: o_count+1, o_dir←1, o_step pulse. Otherwise error 11, count unchanged, no pulse.
  - 3: backward. If o_count > 0: o_count−1, o_dir←0, o_step pulse. Otherwise error 11, count unchanged, no pulse.
  - 2: error 10. Count and o_dir unchanged, no pulse.
  - 0: no action. This occurs after an intervening 0000.
  - In every legal case, including error cases, the phase reference←new phase.
- o_pos is decoded from the o_count register, so it is always coherent with o_count.
- Error capture:
  - On an error event with o_err=0: o_err←1 and o_err_code←code.
  - While o_err=1, later errors do not overwrite o_err_code.
  - i_clr_err=1 clears o_err and o_err_code next cycle.
  - An error event in the same cycle as i_clr_err wins: o_err=1 with the new code.
- Reset values: o_step 0, o_dir 0, o_count 0, o_pos 00, o_locked 0, o_err 0, o_err_code 00. Synchronizer, filter and phase reference also reset.
- Reset asserted mid-operation clears everything immediately, lock included. After release, the first accepted legal phase re-locks without counting.

## Timing

- All outputs are registered except o_pos, which is a decode of the o_count register.
- Latency: a new i_phase value first sampled at edge E0 updates o_step, o_count, o_dir and o_err at edge E0+1+p_stable.
- o_step is high for exactly one cycle. The o_count change is visible in the same cycle o_step is high.
- Minimum step period that is decoded: p_stable cycles per pattern, plus synchronizer skew tolerance of 1 cycle.
- An illegal or 0000 transitional pattern held fewer than p_stable cycles between two legal phases is invisible.
- Reset: asynchronous assertion; release is synchronous to i_clk. No output changes on the release edge itself.

## Test plan

- p_stable=2: reset, drive 1100 then 0110, 0011, 1001, 1100, each held 5 cycles → o_locked=1 after the first, four o_step pulses, o_dir=1, o_count=4, o_pos=10, o_err=0.
- Continue with 1001, 0011 → two pulses, o_dir=0, o_count=2. Then 0110, 1100 → o_count=0, o_pos=00, no error.
- From o_count=0 on phase 1100, drive 1001 → no pulse, o_count=0, o_err=1, o_err_code=11. Pulse i_clr_err → o_err=0, code 00.
- From 1100 drive 0011 → o_err_code=10, no pulse, count unchanged. Then drive 1001 → forward pulse (delta 1 from new reference 0011).
- Insert a 1-cycle 1111 glitch between legal phases → ignored. Hold 1111 for 3 cycles → o_err_code=01. Measure o_step at exactly E0+3 for a legal step.
- p_count_limit=4: step forward to 4 (o_pos=01). One more forward → error 11, count stays 4. Assert i_rst_n low mid-sequence → all outputs at reset values; after release, first legal phase sets o_locked without an o_step pulse.
